// File: rtl/conv_window_feeder.sv
// conv_window_feeder
//
// Streaming 5x5 window generator. Takes a row-major pixel stream, keeps the
// four previous image rows in line buffers, and emits every fully-populated
// (no padding) 5x5 window on a valid/ready output, in raster order.
//
// Parameters:
//   IMG_W - pixels per row (>= 5)
//   IMG_H - rows per frame (>= 5)
//   DW    - pixel width; the data is passed through uninterpreted
//
// Ports:
//   clk        - rising-edge clock
//   rst_n      - asynchronous active-low reset
//   in_pixel   - next pixel, row-major
//   in_valid   - in_pixel is valid
//   in_ready   - pixel is accepted this cycle when in_valid is also high
//   out_window - flattened window, element [r][c] at [(r*5+c)*DW +: DW],
//                r=0 is the oldest row, c=0 the leftmost column
//   out_row    - top-left row of the window
//   out_col    - top-left column of the window
//   out_valid  - window and coordinates are valid
//   out_ready  - consumer takes the window
//   frame_done - one-cycle pulse after the last pixel of a frame is accepted

module conv_window_feeder #(
  parameter int unsigned IMG_W = 32,
  parameter int unsigned IMG_H = 32,
  parameter int unsigned DW    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DW-1:0]            in_pixel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [25*DW-1:0]         out_window,
  output logic [$clog2(IMG_H)-1:0] out_row,
  output logic [$clog2(IMG_W)-1:0] out_col,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     frame_done
);

  localparam int unsigned RW = $clog2(IMG_H);
  localparam int unsigned CW = $clog2(IMG_W);

  // Position of the next pixel to be accepted.
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;

  // Four line buffers; index 0 holds the oldest row.
  logic [DW-1:0] lb_q [4][IMG_W];

  // Window register, [row][col].
  logic [DW-1:0] win_q [5][5];
  logic [DW-1:0] win_d [5][5];

  logic          out_valid_q, out_valid_d;
  logic [RW-1:0] out_row_q, out_row_d;
  logic [CW-1:0] out_col_q, out_col_d;
  logic          frame_done_q, frame_done_d;

  logic          accept;
  logic          last_col;
  logic          last_row;
  logic          qualify;
  logic [DW-1:0] new_col [5];

  // The output register only blocks input while it holds an unconsumed window.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  assign last_col = (col_q == CW'(IMG_W - 1));
  assign last_row = (row_q == RW'(IMG_H - 1));

  // Only positions with four full rows above and four columns to the left
  // produce a window; this also masks the previous row's tail that still sits
  // in the left columns of the window register at the start of each row.
  assign qualify  = (row_q >= RW'(4)) && (col_q >= CW'(4));

  // Column entering the window: buffered rows at col_q plus the new pixel.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      new_col[k] = lb_q[k][col_q];
    end
    new_col[4] = in_pixel;
  end

  // Position counters.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (accept) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Window shift: columns move left, new column enters at column 4.
  always_comb begin
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        win_d[r][c] = win_q[r][c];
      end
    end
    if (accept) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 4; c++) begin
          win_d[r][c] = win_q[r][c + 1];
        end
        win_d[r][4] = new_col[r];
      end
    end
  end

  // Output handshake and coordinates.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
    frame_done_d = accept && last_col && last_row;
    if (accept) begin
      // An accept implies the current window (if any) is consumed this edge.
      out_valid_d = qualify;
      if (qualify) begin
        out_row_d = row_q - RW'(4);
        out_col_d = col_q - CW'(4);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Line buffer storage is not reset: every entry read into a qualified
  // window has been rewritten earlier in the same frame.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_q[0][col_q] <= lb_q[1][col_q];
      lb_q[1][col_q] <= lb_q[2][col_q];
      lb_q[2][col_q] <= lb_q[3][col_q];
      lb_q[3][col_q] <= in_pixel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q        <= '0;
      col_q        <= '0;
      out_valid_q  <= 1'b0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      frame_done_q <= 1'b0;
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 5; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      row_q        <= row_d;
      col_q        <= col_d;
      out_valid_q  <= out_valid_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      frame_done_q <= frame_done_d;
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 5; c++) begin
          win_q[r][c] <= win_d[r][c];
        end
      end
    end
  end

  // The window register is only updated on accept, so it is stable whenever
  // the output is stalled and can drive out_window directly.
  always_comb begin
    out_window = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        out_window[(r * 5 + c) * DW +: DW] = win_q[r][c];
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed/self-checking bench for conv_window_feeder with an 8x8 image.
// Pixel value for frame f of a stream = base + 100*f + 8*row + col.

module tb_conv_window_feeder;

  localparam int unsigned W  = 8;
  localparam int unsigned H  = 8;
  localparam int unsigned D  = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [D-1:0]   in_pixel = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [25*D-1:0] out_window;
  logic [2:0]     out_row;
  logic [2:0]     out_col;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic           frame_done;

  int check_cnt = 0;
  int err_cnt   = 0;

  conv_window_feeder #(
    .IMG_W (W),
    .IMG_H (H),
    .DW    (D)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_pixel   (in_pixel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_window (out_window),
    .out_row    (out_row),
    .out_col    (out_col),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Window whose top-left is (r,c) in a frame whose pixel (0,0) equals base.
  function automatic logic [25*D-1:0] exp_window(input int base, input int r, input int c);
    logic [25*D-1:0] w;
    w = '0;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        w[(i * 5 + j) * D +: D] = 16'(base + 8 * (r + i) + c + j);
      end
    end
    return w;
  endfunction

  // Feed n raster pixels of value i (frame base 0), no checks.
  task automatic feed(input int n, input logic rdy);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_pixel  = 16'(i);
      out_ready = rdy;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Stream nframes frames and check every cycle against a handshake model.
  task automatic run_stream(input string name, input int nframes, input int base0,
                            input bit rand_in, input bit rand_out, input bit stall_first);
    int   total;
    int   pix_idx;
    int   win_idx;
    int   fd_cnt;
    int   cyc;
    int   stall_left;
    bit   m_valid;
    bit   m_fd;
    bit   acc;
    int   f, p, r, c, wf, wr, wc;
    logic [25*D-1:0] ew;

    total      = nframes * 64;
    pix_idx    = 0;
    win_idx    = 0;
    fd_cnt     = 0;
    cyc        = 0;
    stall_left = stall_first ? 10 : 0;
    m_valid    = 1'b0;
    m_fd       = 1'b0;

    while ((pix_idx < total || m_valid) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      f = pix_idx / 64;
      p = pix_idx % 64;
      r = p / 8;
      c = p % 8;
      in_valid = (pix_idx < total) && (rand_in ? ($urandom_range(1, 0) == 1) : 1'b1);
      in_pixel = 16'(base0 + 100 * f + 8 * r + c);
      if (m_valid && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = rand_out ? ($urandom_range(1, 0) == 1) : 1'b1;
      end
      #1;

      check_cnt++;
      if (out_valid !== m_valid) begin
        err_cnt++;
        $display("FAIL %s out_valid cyc=%0d: got %b want %b", name, cyc, out_valid, m_valid);
      end
      check_cnt++;
      if (frame_done !== m_fd) begin
        err_cnt++;
        $display("FAIL %s frame_done cyc=%0d: got %b want %b", name, cyc, frame_done, m_fd);
      end
      check_cnt++;
      if (in_ready !== (!m_valid || out_ready)) begin
        err_cnt++;
        $display("FAIL %s in_ready cyc=%0d: got %b want %b", name, cyc, in_ready,
                 (!m_valid || out_ready));
      end
      if (frame_done === 1'b1) fd_cnt++;

      if (m_valid) begin
        wf = win_idx / 16;
        wr = (win_idx % 16) / 4;
        wc = win_idx % 4;
        ew = exp_window(base0 + 100 * wf, wr, wc);
        check_cnt++;
        if (out_window !== ew) begin
          err_cnt++;
          $display("FAIL %s window #%0d: got %h want %h", name, win_idx, out_window, ew);
        end
        check_cnt++;
        if (out_row !== 3'(wr) || out_col !== 3'(wc)) begin
          err_cnt++;
          $display("FAIL %s coords #%0d: got (%0d,%0d) want (%0d,%0d)", name, win_idx,
                   out_row, out_col, wr, wc);
        end
      end

      // Advance the model across the coming edge.
      acc = in_valid && (!m_valid || out_ready);
      if (m_valid && out_ready) win_idx++;
      m_fd = acc && (p == 63);
      if (acc) begin
        m_valid = (r >= 4) && (c >= 4);
        pix_idx++;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;

    check_cnt++;
    if (cyc >= 5000) begin
      err_cnt++;
      $display("FAIL %s timeout: got %0d pixels want %0d", name, pix_idx, total);
    end
    check_cnt++;
    if (win_idx != 16 * nframes) begin
      err_cnt++;
      $display("FAIL %s window count: got %0d want %0d", name, win_idx, 16 * nframes);
    end
    check_cnt++;
    if (fd_cnt != nframes) begin
      err_cnt++;
      $display("FAIL %s frame_done count: got %0d want %0d", name, fd_cnt, nframes);
    end
  endtask

  task automatic check_reset_values(input string name);
    check_cnt++;
    if (out_valid !== 1'b0 || frame_done !== 1'b0 || in_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL %s handshake: got v=%b fd=%b rdy=%b want 0 0 1", name, out_valid,
               frame_done, in_ready);
    end
    check_cnt++;
    if (out_window !== '0 || out_row !== 3'd0 || out_col !== 3'd0) begin
      err_cnt++;
      $display("FAIL %s data: got win=%h row=%0d col=%0d want 0", name, out_window,
               out_row, out_col);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_frame();
    run_stream("single_frame", 1, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_stream("backpressure", 1, 0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_stream("back_to_back", 2, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    feed(20, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_values("reset_after_20");
    @(negedge clk);
    rst_n = 1'b1;

    // Pixel 36 is (4,4): first window becomes pending and is held.
    feed(37, 1'b0);
    #1;
    check_cnt++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL first_window handshake: got v=%b rdy=%b want 1 0", out_valid, in_ready);
    end
    check_cnt++;
    if (out_window !== exp_window(0, 0, 0) || out_row !== 3'd0 || out_col !== 3'd0) begin
      err_cnt++;
      $display("FAIL first_window data: got %h (%0d,%0d) want %h (0,0)", out_window,
               out_row, out_col, exp_window(0, 0, 0));
    end

    rst_n = 1'b0;
    #1;
    check_reset_values("reset_pending");
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    run_stream("after_reset", 1, 50, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    run_stream("random", 3, 0, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule
